// File: rtl/ram_stream_reader.sv
// Streams LEN consecutive RAM words from BASE_ADDR onto a valid/ready interface.
// The 2-cycle RAM read latency is covered by an in-flight tracker and a credit-limited FIFO.
module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDR_WIDTH:0]   LEN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  RAM_EN,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    input  logic [DATA_WIDTH-1:0] RAM_DOUT,
    output logic                  M_VALID,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_LAST,
    input  logic                  M_READY
);

    localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned USED_W = CNT_W + 1;
    localparam int unsigned ENT_W  = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_ram_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_W-1:0]      r_remain;
    logic                  r_done_zero;

    logic                  r_vld0;
    logic                  r_last0;
    logic                  r_vld1;
    logic                  r_last1;

    logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [USED_W-1:0]     w_used;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_pop;
    logic [ENT_W-1:0]      w_head;

    // Credits cover both FIFO occupancy and words still in the RAM pipe
    assign w_used       = USED_W'(r_count) + USED_W'(r_vld0) + USED_W'(r_vld1);
    assign w_issue      = (r_state == S_ISSUE) && (w_used < USED_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_remain == LEN_W'(1));

    assign w_head     = r_mem[r_rd_ptr];
    assign M_VALID    = (r_count != '0);
    assign M_DATA     = M_VALID ? w_head[DATA_WIDTH-1:0] : '0;
    assign M_LAST     = M_VALID & w_head[DATA_WIDTH];
    assign w_pop      = M_VALID && M_READY;
    assign w_push     = r_ram_en && r_vld1;
    assign w_last_pop = (r_state == S_FLUSH) && w_pop && M_LAST;

    assign BUSY     = (r_state != S_IDLE);
    assign DONE     = r_done_zero | w_last_pop;
    assign RAM_EN   = r_ram_en;
    assign RAM_WE   = 1'b0;
    assign RAM_ADDR = r_addr;

    // Job control; DRAIN leaves as soon as stage 0 is empty, so the final push
    // lands while the FSM is already in FLUSH
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_ram_en    <= 1'b0;
            r_addr      <= '0;
            r_remain    <= '0;
            r_done_zero <= 1'b0;
        end else begin
            r_done_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        if (LEN != '0) begin
                            r_state  <= S_ISSUE;
                            r_ram_en <= 1'b1;
                            r_addr   <= BASE_ADDR;
                            r_remain <= LEN;
                        end else begin
                            r_done_zero <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + ADDR_WIDTH'(1);
                        r_remain <= r_remain - LEN_W'(1);
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_vld0) begin
                        r_state  <= S_FLUSH;
                        r_ram_en <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (w_last_pop) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ram_en <= 1'b0;
                end
            endcase
        end
    end

    // In-flight tracker: advances in lockstep with the RAM output pipe
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_vld0  <= 1'b0;
            r_last0 <= 1'b0;
            r_vld1  <= 1'b0;
            r_last1 <= 1'b0;
        end else if (r_ram_en) begin
            r_vld0  <= w_issue;
            r_last0 <= w_last_issue;
            r_vld1  <= r_vld0;
            r_last1 <= r_last0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_last1, RAM_DOUT};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            assert (!(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))))
                else $error("ram_stream_reader: output FIFO overflow");
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a 2-cycle-latency RAM model.
// Stimulus queues expected words; a negedge monitor pops and compares them.
module tb_ram_stream_reader;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          START = 1'b0;
    logic [AW-1:0] BASE_ADDR = '0;
    logic [AW:0]   LEN = '0;
    logic          BUSY, DONE, RAM_EN, RAM_WE;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_DOUT;
    logic          M_VALID, M_LAST;
    logic [DW-1:0] M_DATA;
    logic          M_READY = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int pops = 0;
    int ready_mode = 0;

    logic [DW:0]   q[$];
    logic [DW:0]   exp_word;
    logic [DW-1:0] prev_data;
    logic          prev_stall = 1'b0;

    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_q_addr;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_DOUT(RAM_DOUT), .M_VALID(M_VALID), .M_DATA(M_DATA), .M_LAST(M_LAST),
        .M_READY(M_READY)
    );

    always #5 CLK = ~CLK;

    // RAM: address register then output register, both gated by EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ram_q_addr <= '0;
            RAM_DOUT   <= '0;
        end else if (RAM_EN) begin
            ram_q_addr <= RAM_ADDR;
            RAM_DOUT   <= ram[ram_q_addr];
        end
    end

    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            1:       M_READY = 1'($urandom_range(0, 1));
            2:       M_READY = 1'b0;
            default: M_READY = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(M_VALID), 32'd1);
                check("hold_data", 32'(M_DATA), 32'(prev_data));
            end
            if (DONE) done_cnt++;
            if (M_VALID && M_READY) begin
                pops++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", M_DATA, $time);
                end else begin
                    exp_word = q.pop_front();
                    check("stream_data", 32'(M_DATA), 32'(exp_word[DW-1:0]));
                    check("stream_last", 32'(M_LAST), 32'(exp_word[DW]));
                    if (exp_word[DW]) check("done_on_last", 32'(DONE), 32'd1);
                end
            end
            prev_stall = M_VALID && !M_READY;
            prev_data  = M_DATA;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, 32'(BUSY), 32'd0);
        check({name, "_done"}, 32'(DONE), 32'd0);
        check({name, "_ram_en"}, 32'(RAM_EN), 32'd0);
        check({name, "_ram_we"}, 32'(RAM_WE), 32'd0);
        check({name, "_ram_addr"}, 32'(RAM_ADDR), 32'd0);
        check({name, "_m_valid"}, 32'(M_VALID), 32'd0);
        check({name, "_m_data"}, 32'(M_DATA), 32'd0);
        check({name, "_m_last"}, 32'(M_LAST), 32'd0);
    endtask

    // Queues the expected words, then pulses START for one cycle
    task automatic start_job(input logic [AW-1:0] base, input logic [AW:0] len);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i);
            q.push_back({(i == int'(len) - 1), ram[a]});
        end
        tick();
        START = 1'b1;
        BASE_ADDR = base;
        LEN = len;
        tick();
        START = 1'b0;
    endtask

    // First four cycles after START: consecutive addresses, first M_VALID in cycle 4
    task automatic check_issue(input string name, input logic [AW-1:0] base);
        logic [AW-1:0] ea;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            ea = base + AW'(k);
            check({name, "_addr"}, 32'(RAM_ADDR), 32'(ea));
            check({name, "_en"}, 32'(RAM_EN), 32'd1);
            check({name, "_busy"}, 32'(BUSY), 32'd1);
            check({name, "_latency"}, 32'(M_VALID), (k == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        tick();
        check({name, "_queue_empty"}, 32'(q.size()), 32'd0);
        check({name, "_busy_after"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int p0;
        bit hit;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = DW'(i);
        ram[10] = 16'hA0A0;
        ram[11] = 16'hA1A1;
        ram[12] = 16'hA2A2;
        ram[13] = 16'hA3A3;

        #2;
        check_outputs_zero("reset");
        repeat (3) tick();
        RESET = 1'b0;
        @(negedge CLK);
        check_outputs_zero("post_reset");

        // Basic job, M_READY held high
        start_job(10, 11'd4);
        check_issue("job1", 10);
        wait_done("job1", 40);
        check("job1_done_count", 32'(done_cnt), 32'd1);

        // Stalled consumer: only FIFO_DEPTH words may be issued, then no gaps
        ready_mode = 2;
        start_job(10, 11'd8);
        repeat (20) @(negedge CLK);
        check("stall_addr", 32'(RAM_ADDR), 32'd14);
        check("stall_valid", 32'(M_VALID), 32'd1);
        check("stall_busy", 32'(BUSY), 32'd1);
        ready_mode = 0;
        @(posedge CLK);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check("release_no_gap", 32'(M_VALID), 32'd1);
            check("release_done", 32'(DONE), (k == 7) ? 32'd1 : 32'd0);
        end
        tick();
        check("release_queue_empty", 32'(q.size()), 32'd0);
        check("release_busy_after", 32'(BUSY), 32'd0);

        // Address wrap
        start_job(10'd1022, 11'd4);
        check_issue("wrap", 10'd1022);
        wait_done("wrap", 40);

        // LEN = 0
        tick();
        START = 1'b1;
        BASE_ADDR = 10'd5;
        LEN = '0;
        tick();
        START = 1'b0;
        @(negedge CLK);
        check("len0_done", 32'(DONE), 32'd1);
        check("len0_busy", 32'(BUSY), 32'd0);
        check("len0_ram_en", 32'(RAM_EN), 32'd0);
        check("len0_valid", 32'(M_VALID), 32'd0);
        @(negedge CLK);
        check("len0_done_drop", 32'(DONE), 32'd0);
        check("len0_ram_en2", 32'(RAM_EN), 32'd0);

        // START while busy is ignored
        d0 = done_cnt;
        start_job(10'd100, 11'd6);
        repeat (2) tick();
        START = 1'b1;
        BASE_ADDR = 10'd500;
        LEN = 11'd3;
        tick();
        START = 1'b0;
        wait_done("restart", 60);
        repeat (6) tick();
        check("restart_done_count", 32'(done_cnt - d0), 32'd1);
        check("restart_idle_en", 32'(RAM_EN), 32'd0);

        // Reset during the third stream word of a LEN=8 job
        d0 = done_cnt;
        p0 = pops;
        hit = 1'b0;
        start_job(10'd200, 11'd8);
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            #2;
            if (pops - p0 == 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("reset_third_word_reached", 32'(hit), 32'd1);
        RESET = 1'b1;
        #1;
        check_outputs_zero("midjob_reset");
        q.delete();
        repeat (2) tick();
        RESET = 1'b0;
        check("midjob_no_done", 32'(done_cnt - d0), 32'd0);
        start_job(10'd300, 11'd2);
        wait_done("after_reset", 40);
        check("after_reset_done_count", 32'(done_cnt - d0), 32'd1);

        // Full-depth job with a random 50% consumer
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = DW'(i);
        ready_mode = 1;
        start_job(10'd0, 11'd1024);
        wait_done("random", 8000);
        ready_mode = 0;
        check("random_ram_we", 32'(RAM_WE), 32'd0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
